// File: rtl/ep_host_seq.sv
// Host-side sequencer for endpoint wire-in/wire-out bus transactions.
// Define EP_ADDR_CHECK_EN to reject out-of-range addresses with an error response.
module ep_host_seq #(
    parameter int unsigned RD_LATENCY  = 2,
    parameter logic [7:0]  WR_ADDR_MAX = 8'h1F
) (
    input  logic        okClk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wr_strobe,
    output logic        bus_update_strobe,
    output logic        bus_rd_strobe,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("ep_host_seq: RD_LATENCY must be 1..7");
    end
    if (WR_ADDR_MAX >= 8'h20) begin : g_bad_wr_max
        $error("ep_host_seq: WR_ADDR_MAX overlaps the wire-out range");
    end

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WR, UPD, RD_REQ, RD_WAIT, RESP} state_t;

    state_t      state, nxt;
    logic        armed;
    logic        accept;
    logic        acc_bad;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  cnt;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

`ifdef EP_ADDR_CHECK_EN
    assign acc_bad = cmd_write ? (cmd_addr > WR_ADDR_MAX)
                               : ((cmd_addr < 8'h20) || (cmd_addr > 8'h3F));
`else
    assign acc_bad = 1'b0;
`endif

    assign accept   = cmd_valid && cmd_ready;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge okClk or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    always_ff @(posedge okClk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt               = state;
        cmd_ready         = 1'b0;
        bus_wr_strobe     = 1'b0;
        bus_update_strobe = 1'b0;
        bus_rd_strobe     = 1'b0;
        bus_addr          = 8'h00;
        bus_wdata         = 32'h0;
        rsp_valid         = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = armed;
                if (cmd_valid && armed)
                    nxt = acc_bad ? RESP : (cmd_write ? WR : RD_REQ);
            end
            WR: begin
                bus_wr_strobe = 1'b1;
                bus_addr      = addr_q;
                bus_wdata     = wdata_q;
                nxt           = UPD;
            end
            UPD: begin
                bus_update_strobe = 1'b1;
                bus_addr          = addr_q;
                nxt               = RESP;
            end
            RD_REQ: begin
                bus_rd_strobe = 1'b1;
                bus_addr      = addr_q;
                nxt           = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt == 3'd0) nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge okClk or posedge reset) begin
        if (reset) begin
            addr_q     <= 8'h00;
            wdata_q    <= 32'h0;
            cnt        <= 3'd0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept && acc_bad) begin
                        rsp_data_q <= 32'hDEAD_0000 | {24'h0, cmd_addr};
                        rsp_err_q  <= 1'b1;
                    end
                end
                UPD: begin
                    rsp_data_q <= 32'h0;
                    rsp_err_q  <= 1'b0;
                end
                RD_REQ: cnt <= CNT_INIT;
                RD_WAIT: begin
                    // Last wait cycle lines up with the bus's read latency.
                    if (cnt == 3'd0) begin
                        rsp_data_q <= bus_rdata;
                        rsp_err_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
